// File: rtl/dmem_arb_pkg.sv
// Shared types and requester slot assignments for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  localparam int REQ_UART = 0;
  localparam int REQ_PROC = 1;
  localparam int REQ_DBG  = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or after ptr, wrapping,
// skipping any requester set in the exclude mask.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  exclude,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] cand;
  int           slot;

  assign cand = req & ~exclude;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    slot  = 0;
    for (int k = 0; k < N; k++) begin
      slot = (int'(ptr) + k) % N;
      if (!found && cand[slot]) begin
        found = 1'b1;
        idx   = IW'(slot);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between
// REQ_COUNT requesters, with per-requester read-valid tracking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int REQ_COUNT   = 3,
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_COUNT-1:0]             req,
  input  logic [REQ_COUNT-1:0]             lock,
  input  logic [REQ_COUNT-1:0]             wrEn,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0]  addr,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0]  dataIn,
  output logic [REQ_COUNT-1:0]             grant,
  output logic [REQ_COUNT-1:0]             rdValid,
  output logic [DATA_WIDTH-1:0]            rdData,
  output logic                             busy,
  output logic                             memWrEn,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic [DATA_WIDTH-1:0]            memDataIn,
  input  logic [DATA_WIDTH-1:0]            memDataOut
);

  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(REQ_COUNT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST - 1);

  arb_state_t           state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        pointer;
  logic [BW-1:0]        burst;
  logic [REQ_COUNT-1:0] ownerMask;
  logic                 ownerReq;
  logic                 ownerLock;
  logic                 othersWait;
  logic                 access;
  logic [IW-1:0]        nextPtr;
  logic [IW-1:0]        searchPtr;
  logic [REQ_COUNT-1:0] searchExcl;
  logic [IW-1:0]        pickIdx;
  logic                 pickFound;

  logic [MEM_LATENCY-1:0] pipeVld;
  logic [IW-1:0]          pipeId [MEM_LATENCY];

  assign ownerMask  = REQ_COUNT'(1) << owner;
  assign ownerReq   = |(req & ownerMask);
  assign ownerLock  = |(lock & ownerMask);
  assign othersWait = |(req & ~ownerMask);
  assign nextPtr    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign access     = (state == GRANTED) && ownerReq;
  assign busy       = (state == GRANTED);

  // While granted, the search starts just past the owner and never re-picks it.
  assign searchPtr  = (state == GRANTED) ? nextPtr : pointer;
  assign searchExcl = (state == GRANTED) ? ownerMask : '0;

  rr_picker #(
    .N (REQ_COUNT),
    .IW(IW)
  ) picker (
    .req    (req),
    .ptr    (searchPtr),
    .exclude(searchExcl),
    .idx    (pickIdx),
    .found  (pickFound)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      pointer <= '0;
      burst   <= '0;
      grant   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickFound) begin
            state <= GRANTED;
            owner <= pickIdx;
            grant <= REQ_COUNT'(1) << pickIdx;
            burst <= '0;
          end
        end
        GRANTED: begin
          if (!ownerReq || (othersWait && (!ownerLock || burst == BURST_MAX))) begin
            pointer <= nextPtr;
            burst   <= '0;
            if (pickFound) begin
              owner <= pickIdx;
              grant <= REQ_COUNT'(1) << pickIdx;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (othersWait && burst != BURST_MAX) begin
            burst <= burst + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    memWrEn   = 1'b0;
    memAddr   = '0;
    memDataIn = '0;
    if (access) begin
      memWrEn   = |(wrEn & ownerMask);
      memAddr   = addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
      memDataIn = dataIn[owner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reads carry their requester id down the pipe so hand-overs don't misroute data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeVld <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipeId[i] <= '0;
    end else begin
      pipeVld[0] <= access && !memWrEn;
      pipeId[0]  <= owner;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipeVld[i] <= pipeVld[i-1];
        pipeId[i]  <= pipeId[i-1];
      end
    end
  end

  assign rdValid = pipeVld[MEM_LATENCY-1] ? (REQ_COUNT'(1) << pipeId[MEM_LATENCY-1]) : '0;
  assign rdData  = memDataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized
// requester traffic checked against a cycle-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int N  = 3;
  localparam int DW = 12;
  localparam int AW = 12;
  localparam int MAXB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, lock, wrEn;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] dataIn;
  logic [N-1:0]   grant, rdValid;
  logic [DW-1:0]  rdData;
  logic           busy, memWrEn;
  logic [AW-1:0]  memAddr;
  logic [DW-1:0]  memDataIn, memDataOut;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rdExp_t;

  rdExp_t        sbQ[$];
  logic [DW-1:0] ram    [1 << AW];
  logic [DW-1:0] refMem [1 << AW];
  int            modelOwner = -1;
  int            modelPtr   = 0;
  int            modelBurst = 0;
  logic [N-1:0]  accessed   = '0;
  int            accessCount [N];
  int            cycle  = 0;
  int            checks = 0;
  int            errors = 0;

  dmem_arbiter #(
    .REQ_COUNT  (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_LATENCY(1),
    .MAX_BURST  (MAXB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .wrEn      (wrEn),
    .addr      (addr),
    .dataIn    (dataIn),
    .grant     (grant),
    .rdValid   (rdValid),
    .rdData    (rdData),
    .busy      (busy),
    .memWrEn   (memWrEn),
    .memAddr   (memAddr),
    .memDataIn (memDataIn),
    .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWrEn) ram[memAddr] <= memDataIn;
    memDataOut <= ram[memAddr];
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  function automatic int pickFrom(input int start, input logic [N-1:0] r, input int excl);
    for (int k = 0; k < N; k++) begin
      int j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  // Reference model: who owns the RAM this cycle, what it must see, and who owns it next.
  always @(negedge clk) begin : modelProc
    logic          acc, others, keep;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [63:0]   expPort;
    if (rst) begin
      checkOutput("resetQuiet", 64'({grant, rdValid, busy, memWrEn}), 64'd0);
      modelOwner = -1;
      modelPtr   = 0;
      modelBurst = 0;
      accessed   = '0;
      sbQ.delete();
    end else begin
      checkOutput("grant", 64'(grant), (modelOwner >= 0) ? (64'd1 << modelOwner) : 64'd0);
      checkOutput("busy", 64'(busy), 64'(modelOwner >= 0));
      acc      = (modelOwner >= 0) && req[modelOwner];
      accessed = '0;
      expPort  = 64'd0;
      if (acc) begin
        a = addr[modelOwner*AW +: AW];
        d = dataIn[modelOwner*DW +: DW];
        expPort = 64'({wrEn[modelOwner], a, d});
        accessed[modelOwner] = 1'b1;
        accessCount[modelOwner]++;
        if (wrEn[modelOwner]) refMem[a] = d;
        else sbQ.push_back('{id: modelOwner, data: refMem[a], due: cycle + 1});
      end
      checkOutput("memPort", 64'({memWrEn, memAddr, memDataIn}), expPort);

      if (modelOwner < 0) begin
        modelOwner = pickFrom(modelPtr, req, -1);
        modelBurst = 0;
      end else begin
        others = |(req & ~(N'(1) << modelOwner));
        keep   = req[modelOwner] &&
                 ((lock[modelOwner] && (modelBurst < MAXB - 1 || !others)) || !others);
        if (!keep) begin
          modelPtr   = (modelOwner + 1) % N;
          modelOwner = pickFrom(modelPtr, req, modelOwner);
          modelBurst = 0;
        end else if (others && modelBurst < MAXB - 1) begin
          modelBurst++;
        end
      end
    end
  end

  // Monitor: every read-valid must match the oldest outstanding expected read.
  always @(negedge clk) begin : monitorProc
    rdExp_t e;
    if (!rst) begin
      if (rdValid != '0) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rdUnexpected: got rdValid %b, required 000", rdValid);
        end else begin
          e = sbQ.pop_front();
          checkOutput("rdValid", 64'(rdValid), 64'd1 << e.id);
          checkOutput("rdData", 64'(rdData), 64'(e.data));
          checkOutput("rdLatency", 64'(cycle), 64'(e.due));
        end
      end else if (sbQ.size() > 0 && sbQ[0].due <= cycle) begin
        e = sbQ.pop_front();
        checkOutput("rdMissing", 64'(rdValid), 64'd1 << e.id);
      end
    end
  end

  task automatic setSlot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]   = a;
    dataIn[i*DW +: DW] = d;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] w, input int n);
    req  = r;
    lock = l;
    wrEn = w;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    wrEn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) accessCount[i] = 0;
  endtask

  task automatic newTxn(input int i);
    req[i]  = 1'b1;
    lock[i] = 1'($urandom_range(0, 1));
    wrEn[i] = 1'($urandom_range(0, 1));
    setSlot(i, AW'($urandom_range(0, 15)), DW'($urandom));
  endtask

  task automatic runRandom(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !accessed[i]) continue;
        if (req[i]) begin
          if ($urandom_range(0, 9) < 7) newTxn(i);
          else req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          newTxn(i);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = '0;
      refMem[i] = '0;
    end
    addr   = '0;
    dataIn = '0;

    // Two requests out of reset, then the winner drops with the other waiting.
    doReset();
    applyStimulus(3'b101, 3'b000, 3'b000, 1);
    #1 checkOutput("t1FirstGrant", 64'(grant), 64'b001);
    applyStimulus(3'b100, 3'b000, 3'b000, 1);
    #1 checkOutput("t1NoBubble", 64'(grant), 64'b100);

    // Read of a known location by the processor slot.
    doReset();
    setSlot(REQ_PROC, 12'h005, 12'h0AB);
    applyStimulus(3'b010, 3'b000, 3'b010, 2);
    wrEn = 3'b000;
    #1 checkOutput("t2MemAddr", 64'({memWrEn, memAddr}), 64'({1'b0, 12'h005}));
    applyStimulus(3'b010, 3'b000, 3'b000, 1);
    req = 3'b000;
    #1 checkOutput("t2RdValid", 64'(rdValid), 64'b010);
    checkOutput("t2RdData", 64'(rdData), 64'h0AB);

    // Locked write burst hits the burst limit while another requester waits.
    doReset();
    setSlot(REQ_UART, 12'h001, 12'h111);
    setSlot(REQ_PROC, 12'h002, 12'h000);
    applyStimulus(3'b011, 3'b001, 3'b001, 17);
    #1 checkOutput("t3HandOver", 64'(grant), 64'b010);
    checkOutput("t3BurstLen", 64'(accessCount[REQ_UART]), 64'd16);
    applyStimulus(3'b011, 3'b001, 3'b001, 1);
    applyStimulus(3'b001, 3'b001, 3'b001, 3);
    #1 checkOutput("t3Regain", 64'(grant), 64'b001);
    checkOutput("t3TotalWrites", 64'(accessCount[REQ_UART]), 64'd19);

    // Two unlocked requesters alternate one access each.
    doReset();
    applyStimulus(3'b101, 3'b000, 3'b000, 10);
    #1 checkOutput("t4Grant", 64'(grant), 64'b100);
    checkOutput("t4Count0", 64'(accessCount[REQ_UART]), 64'd5);
    checkOutput("t4Count2", 64'(accessCount[REQ_DBG]), 64'd4);

    // Reset mid-burst with a read in flight.
    doReset();
    setSlot(REQ_UART, 12'h003, 12'h055);
    applyStimulus(3'b001, 3'b001, 3'b001, 2);
    applyStimulus(3'b001, 3'b001, 3'b000, 1);
    wrEn = 3'b001;
    rst  = 1'b1;
    #1 checkOutput("t5ResetQuiet", 64'({grant, rdValid, memWrEn, busy}), 64'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(3'b100, 3'b000, 3'b000, 1);
    #1 checkOutput("t5AfterReset", 64'(grant), 64'b100);

    // Previous owner's read returns after the hand-over.
    doReset();
    setSlot(REQ_PROC, 12'h007, 12'h000);
    setSlot(REQ_DBG, 12'h009, 12'h123);
    applyStimulus(3'b010, 3'b000, 3'b000, 1);
    applyStimulus(3'b110, 3'b000, 3'b100, 1);
    req = 3'b100;
    #1 checkOutput("t6GrantDbg", 64'(grant), 64'b100);
    checkOutput("t6RdValidProc", 64'(rdValid), 64'b010);
    applyStimulus(3'b100, 3'b000, 3'b100, 1);
    #1 checkOutput("t6NoRdValidDbg", 64'(rdValid), 64'b000);
    applyStimulus(3'b000, 3'b000, 3'b000, 2);

    // Randomized traffic against the reference model.
    doReset();
    runRandom(3000);
    applyStimulus(3'b000, 3'b000, 3'b000, 4);
    checkOutput("drain", 64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
